// File: rtl/strobe_pulse_pkg.sv
// Shared types and helpers for the strobe pulse stretcher.
// Holds the FSM state encoding and the counter width calculation.
// No logic. Imported by strobe_pulse_gen.
package strobe_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } pulse_state_t;

  // Bits needed to hold the larger of the two cycle counts.
  function automatic int cnt_width(int a, int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/strobe_pulse_gen_timer.sv
// Loadable down-counter that times the HIGH and GAP phases.
// Latency: load takes effect the cycle after load_i; done_o is combinational from the count.
// Backpressure: none; load_i always wins over counting down.
module pulse_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/strobe_pulse_gen.sv
// Stretches single-cycle strobes into PULSE_CYCLES-high pulses, each followed by a GAP_CYCLES low gap.
// Latency: pulse_o rises the cycle after an accepted strobe; outputs are registered.
// Backpressure: none; strobes arriving while busy are queued (STROBE_PULSE_QUEUE_EN) or dropped, with drops flagged on overflow_o.
module strobe_pulse_gen
  import strobe_pulse_pkg::*;
#(
  parameter int PULSE_CYCLES = 1_200_000,
  parameter int GAP_CYCLES   = 600_000,
  parameter int PEND_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              strobe_i,
  output logic              pulse_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o
);

  localparam int CW = cnt_width(PULSE_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

  pulse_state_t  state_q;
  logic          pulse_q;
  logic          busy_q;
  logic          overflow_q;
  logic          timer_done;
  logic          timer_load;
  logic [CW-1:0] timer_load_val;
  logic          pend_nz;
  logic          gap_term;
  logic          late_strobe;

  // Last cycle of the gap: the only point where a new pulse may follow an old one.
  assign gap_term = (state_q == GAP) && timer_done;

  // A strobe seen while busy that cannot start a pulse directly.
  assign late_strobe = strobe_i && (state_q != IDLE) && !(gap_term && !pend_nz);

  // Timer reload at each phase entry.
  always_comb begin
    timer_load     = 1'b0;
    timer_load_val = PULSE_LOAD;
    case (state_q)
      IDLE: timer_load = strobe_i;
      HIGH: begin
        timer_load     = timer_done;
        timer_load_val = GAP_LOAD;
      end
      GAP:     timer_load = timer_done && (pend_nz || strobe_i);
      default: timer_load = 1'b0;
    endcase
  end

  pulse_timer #(
    .W (CW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (timer_load_val),
    .done_o     (timer_done)
  );

  // Phase sequencing with pulse/busy registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (strobe_i) begin
            state_q <= HIGH;
            pulse_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        HIGH: begin
          if (timer_done) begin
            state_q <= GAP;
            pulse_q <= 1'b0;
          end
        end
        GAP: begin
          if (timer_done) begin
            if (pend_nz || strobe_i) begin
              state_q <= HIGH;
              pulse_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef STROBE_PULSE_QUEUE_EN
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0] pend_q;
  logic              deq;

  assign deq     = gap_term && pend_nz;
  assign pend_nz = (pend_q != '0);

  // Pending count; an enqueue that meets a dequeue leaves the count unchanged and is not a drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= '0;
      overflow_q <= 1'b0;
    end else if (late_strobe && deq) begin
      pend_q <= pend_q;
    end else if (deq) begin
      pend_q <= pend_q - 1'b1;
    end else if (late_strobe) begin
      if (pend_q == PEND_MAX) begin
        overflow_q <= 1'b1;
      end else begin
        pend_q <= pend_q + 1'b1;
      end
    end
  end

  assign pending_o = pend_q;
`else
  assign pend_nz   = 1'b0;
  assign pending_o = '0;

  // Without a queue every late strobe is a drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (late_strobe) begin
      overflow_q <= 1'b1;
    end
  end
`endif

  assign pulse_o    = pulse_q;
  assign busy_o     = busy_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_strobe_pulse_gen.sv
// Bench for strobe_pulse_gen with PULSE_CYCLES=4, GAP_CYCLES=2, PEND_W=2.
// A position-in-period reference model is checked every cycle, plus literal scenario checks.
// Queue-specific scenarios follow STROBE_PULSE_QUEUE_EN.
module tb_strobe_pulse_gen;

  localparam int P    = 4;
  localparam int G    = 2;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;
`ifdef STROBE_PULSE_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          strobe_i = 1'b0;
  logic          pulse_o;
  logic          busy_o;
  logic [PW-1:0] pending_o;
  logic          overflow_o;

  int errors = 0;
  int checks = 0;

  // Reference model: active flag, position within the P+G period, queued count, sticky drop flag.
  bit m_active = 1'b0;
  int m_pos    = 0;
  int m_pend   = 0;
  bit m_ovf    = 1'b0;

  always #5 clk = ~clk;

  strobe_pulse_gen #(
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G),
    .PEND_W       (PW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .strobe_i   (strobe_i),
    .pulse_o    (pulse_o),
    .busy_o     (busy_o),
    .pending_o  (pending_o),
    .overflow_o (overflow_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit s);
    if (r) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_pend   = 0;
      m_ovf    = 1'b0;
    end else if (!m_active) begin
      if (s) begin
        m_active = 1'b1;
        m_pos    = 0;
      end
    end else if (m_pos == P + G - 1) begin
      if (m_pend > 0) begin
        m_pos = 0;
        if (!s) m_pend--;
      end else if (s) begin
        m_pos = 0;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_pos++;
      if (s) begin
        if (QEN && m_pend < PMAX) m_pend++;
        else m_ovf = 1'b1;
      end
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, compare shortly after.
  task automatic step(input bit r, input bit s);
    @(negedge clk);
    reset    = r;
    strobe_i = s;
    @(posedge clk);
    model_update(r, s);
    #1;
    chk("m_pulse", int'(pulse_o), int'(m_active && (m_pos < P)));
    chk("m_busy", int'(busy_o), int'(m_active));
    chk("m_pending", int'(pending_o), m_pend);
    chk("m_overflow", int'(overflow_o), int'(m_ovf));
  endtask

  initial begin
    logic [6:0] pv;
    int hc;
    int n;
    int dens;

    // Reset held with strobe toggling.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, i[0] ? 1'b0 : 1'b1);
      chk("rst_pulse", int'(pulse_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_pending", int'(pending_o), 0);
      chk("rst_overflow", int'(overflow_o), 0);
    end
    step(1'b0, 1'b0);
    chk("rst_release_busy", int'(busy_o), 0);

    // Single strobe: 4 high, 2 low, idle at cycle 7.
    pv = '0;
    step(1'b0, 1'b1);
    pv[0] = pulse_o;
    for (int k = 1; k < 7; k++) begin
      step(1'b0, 1'b0);
      pv[k] = pulse_o;
      if (k == 5) chk("single_busy_c6", int'(busy_o), 1);
    end
    chk("single_pattern", int'(pv), 7'b0001111);
    chk("single_idle_c7", int'(busy_o), 0);

`ifdef STROBE_PULSE_QUEUE_EN
    // Three strobes during HIGH: queue depth 1,2,3 then four pulses total.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    hc = 1;
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b1);
      chk("queue_depth", int'(pending_o), k);
      hc += int'(pulse_o);
    end
    n = 0;
    while (busy_o && n < 40) begin
      step(1'b0, 1'b0);
      hc += int'(pulse_o);
      n++;
    end
    chk("queue_drain_bound", int'(n < 40), 1);
    chk("queue_high_cycles", hc, 16);
    chk("queue_empty", int'(pending_o), 0);
    chk("queue_no_ovf", int'(overflow_o), 0);

    // Four strobes during HIGH: saturate at 3, sticky overflow.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1);
    chk("sat_pending", int'(pending_o), 3);
    chk("sat_overflow", int'(overflow_o), 1);
    for (int k = 0; k < 30; k++) step(1'b0, 1'b0);
    chk("sat_overflow_sticky", int'(overflow_o), 1);
    chk("sat_drained", int'(pending_o), 0);
    step(1'b1, 1'b0);
    chk("sat_reset_clears", int'(overflow_o), 0);

    // Strobe together with dequeue at the gap's last cycle, pending 2.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("deq_pre_pending", int'(pending_o), 2);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("deq_net_zero", int'(pending_o), 2);
    chk("deq_new_pulse", int'(pulse_o), 1);
    step(1'b1, 1'b0);
`else
    // No queue: strobe during HIGH is dropped.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    hc = 1;
    step(1'b0, 1'b1);
    hc += int'(pulse_o);
    chk("noq_overflow", int'(overflow_o), 1);
    chk("noq_pending", int'(pending_o), 0);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0);
      hc += int'(pulse_o);
    end
    chk("noq_single_pulse", hc, 4);
    chk("noq_overflow_sticky", int'(overflow_o), 1);
    step(1'b1, 1'b0);
`endif

    // Strobe in the gap's last cycle with nothing queued starts the next pulse at once.
    step(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("direct_pulse", int'(pulse_o), 1);
    chk("direct_pending", int'(pending_o), 0);
    chk("direct_no_ovf", int'(overflow_o), 0);

    // Reset mid-HIGH aborts; a fresh strobe gives a full pulse.
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("abort_pulse", int'(pulse_o), 0);
    chk("abort_pending", int'(pending_o), 0);
    step(1'b0, 1'b0);
    chk("abort_idle", int'(busy_o), 0);
    hc = 0;
    step(1'b0, 1'b1);
    hc += int'(pulse_o);
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b0);
      hc += int'(pulse_o);
    end
    chk("abort_full_pulse", hc, 4);

    // Random traffic at varying strobe densities with rare resets.
    dens = 5;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       dens = 5;
          1:       dens = 30;
          default: dens = 70;
        endcase
      end
      step($urandom_range(0, 249) == 0, $urandom_range(0, 99) < dens);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
